// File: rtl/mb_rx_deframer.sv
// Mainband RX deframer: samples 16 data lanes + valid per UI, rebuilds 64-byte flits from four 8-UI fragments, buffers them in a flit FIFO.
// Latency: valid_o rises right after the edge sampling UI 31 (no extra stage); throughput one flit per 32 UIs.
// Backpressure: valid/ready drain; a flit completing into a full FIFO with no same-edge pop is dropped and sets sticky overflow_o.
// Optional: `define MB_RX_FRAMING_CHECK_EN enables valid-lane framing checks (framing_err_o).
module mb_rx_deframer #(
    parameter int flit_buffer_size = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dataPins_i,
    input  logic        valid_pin_i,
    output logic [7:0]  data_o [64],
    output logic        valid_o,
    input  logic        ready_i,
    output logic        receiving_o,
    output logic        overflow_o,
    output logic        framing_err_o
);

    localparam int PTR_W = $clog2(flit_buffer_size);
    localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(flit_buffer_size);

    typedef enum logic {S_IDLE, S_RECV} state_t;

    state_t           state_q, state_d;
    logic [2:0]       ui_ctr;
    logic [1:0]       frag_ctr;
    logic [7:0]       asm_q  [64];
    logic [7:0]       flit_d [64];
    logic             sample_en, commit, frame_bad, last_ui;
    logic [7:0]       slot_q [flit_buffer_size][64];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             pop, full, push;

    assign last_ui = (ui_ctr == 3'd7) && (frag_ctr == 2'd3);

`ifdef MB_RX_FRAMING_CHECK_EN
    // Valid lane must be high on UIs 0-3 and low on UIs 4-7 of every fragment.
    assign frame_bad = (state_q == S_RECV) && (valid_pin_i != (ui_ctr < 3'd4));
`else
    assign frame_bad = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: leave IDLE on valid, return after UI 31 or on a framing violation
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (valid_pin_i) state_d = S_RECV;
            S_RECV: if (frame_bad || last_ui) state_d = S_IDLE;
        endcase
    end

    // FSM outputs: when to sample the lanes and when the flit is complete
    always_comb begin
        sample_en   = 1'b0;
        commit      = 1'b0;
        receiving_o = 1'b0;
        case (state_q)
            S_IDLE: sample_en = valid_pin_i;
            S_RECV: begin
                receiving_o = 1'b1;
                sample_en   = !frame_bad;
                commit      = last_ui && !frame_bad;
            end
        endcase
    end

    // Merge this UI's lane bits into the assembly image; the committed flit includes UI 31
    always_comb begin
        flit_d = asm_q;
        for (int i = 0; i < 16; i++) begin
            flit_d[{frag_ctr, i[3:0]}][ui_ctr] = dataPins_i[i];
        end
    end

    // UI/fragment counters and assembly register; counters wrap to 0 after UI 31
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ui_ctr   <= '0;
            frag_ctr <= '0;
            for (int b = 0; b < 64; b++) asm_q[b] <= '0;
        end else if (frame_bad) begin
            ui_ctr   <= '0;
            frag_ctr <= '0;
        end else if (sample_en) begin
            ui_ctr <= ui_ctr + 3'd1;
            if (ui_ctr == 3'd7) frag_ctr <= frag_ctr + 2'd1;
            asm_q <= flit_d;
        end
    end

    // Framing error pulse, registered so it appears one cycle after the bad edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) framing_err_o <= 1'b0;
        else        framing_err_o <= frame_bad;
    end

    assign valid_o = (count != '0);
    assign pop     = valid_o && ready_i;
    assign full    = (count == DEPTH);
    // A commit into a full FIFO still lands when the head leaves on the same edge
    assign push    = commit && (!full || pop);

    // Flit FIFO: slot writes, pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            for (int s = 0; s < flit_buffer_size; s++)
                for (int b = 0; b < 64; b++) slot_q[s][b] <= '0;
        end else begin
            if (push) begin
                slot_q[wr_ptr] <= flit_d;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (commit && full && !pop) overflow_o <= 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Head-of-FIFO flit presented to the consumer
    always_comb begin
        for (int b = 0; b < 64; b++) data_o[b] = slot_q[rd_ptr][b];
    end

endmodule

// File: doc/mb_rx_deframer.md
# mb_rx_deframer

Mainband receive deframer for the 16-lane UCIe standard-package link. It samples the 16 data pins and the valid pin once per UI and rebuilds each 64-byte flit from four 8-UI fragments. Complete flits go into a small flit FIFO, and the FIFO drains to the adapter side through a valid/ready handshake. It is the far-end counterpart of the mainband transmitter: it consumes the transmitter's exact lane, fragment and valid framing.

## Interface
Parameters:
- flit_buffer_size, 4, FIFO depth in flits; power of 2, ≥2.

Ports:
- clk  in  1  receive clock, one UI per rising edge (forwarded-clock domain). Single clock for the whole block.
- reset  in  1  asynchronous, active-low reset.
- dataPins_i  in  16  mainband data lanes; lane i carries byte (frag*16 + i).
- valid_pin_i  in  1  mainband valid lane.
- data_o  out  [7:0] x 64  head flit of the FIFO; byte k is data_o[k].
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer accepts the head flit when valid_o && ready_i.
- receiving_o  out  1  a flit is being assembled (state RECV).
- overflow_o  out  1  sticky; a complete flit was dropped because the FIFO was full.
- framing_err_o  out  1  one-cycle pulse on a framing violation.

## Operation
- Wire format per fragment: 8 consecutive UIs. On UI u (0..7), lane i carries bit u of its byte, LSB first.
- valid_pin_i is 1 on UIs 0–3 and 0 on UIs 4–7 of every fragment.
- Fragments 0..3 of one flit are back-to-back, with no idle UIs between them.
- Counters:
  - ui_ctr is 3 bits and wraps 7→0.
  - frag_ctr is 2 bits and advances when ui_ctr wraps.
  - Assembly register: 64 x 8 bits. The UI u sample of lane i is written to byte[frag_ctr*16+i] bit u.
- FSM states and transitions:
  - IDLE: on valid_pin_i=1, sample UI 0 of fragment 0, set ui_ctr=1, go to RECV.
  - RECV: sample every UI. After UI 7 of fragment 3 (the 32nd UI), commit the flit and go to IDLE.
  - In IDLE, the next flit may start on the very next cycle.
- Commit: the flit, including the UI 31 bits sampled on that same edge, is written to FIFO slot write_index.
  - If the FIFO is not full, write_index increments.
  - If the FIFO is full and no pop happens in the same cycle, the flit is dropped and overflow_o is set. overflow_o clears only on reset.
- FIFO:
  - Pointers are log2(flit_buffer_size) bits wide and wrap naturally. count is log2(flit_buffer_size)+1 bits wide.
  - Pop when valid_o && ready_i.
  - Commit and pop on the same edge leave count unchanged. A commit while full is accepted if a pop occurs on that same edge.
- data_o = slot[read_index]. Its value is don't-care while valid_o=0.

## Timing
- Reset values: FSM=IDLE, ui_ctr=0, frag_ctr=0, pointers=0, count=0, valid_o=0, receiving_o=0, overflow_o=0, framing_err_o=0. The assembly register and slots reset to 0.
- Latency: valid_o rises immediately after the clk edge that samples UI 31; there is no extra pipeline stage.
- Throughput: one flit per 32 cycles, sustained with no idle UIs between flits.
- receiving_o is high from the edge after UI 0 through the edge that samples UI 31. It is low after commit.
- A reset assertion mid-flit discards the partial flit and empties the FIFO asynchronously.
- framing_err_o pulses one cycle after the offending edge.

## Configuration
- MB_RX_FRAMING_CHECK_EN defined:
  - In RECV, valid_pin_i is checked against the expected value: 1 for ui_ctr 0–3, 0 for ui_ctr 4–7.
  - Any mismatch pulses framing_err_o, discards the partial flit, and returns to IDLE.
  - The mismatching UI is not reused as a start. A new flit starts only on a later valid_pin_i=1 seen in IDLE.
- Not defined:
  - valid_pin_i is used only to leave IDLE, and RECV counts 32 UIs unconditionally.
  - framing_err_o is tied 0.

## Test plan
- Single flit: send byte k = k (0x00..0x3F) in the wire format with ready_i=1. Required: valid_o rises after UI 31, data_o[k]=k, and one pop returns valid_o to 0.
- Back-to-back: send 4 flits with no gaps (byte k of flit n = k^(n<<6)) and hold ready_i=0. Required: count=4, overflow_o=0, and 4 flits read out in order with correct data.
- Overflow: send 5 flits with ready_i=0 and flit_buffer_size=4. Required: overflow_o=1 after the 5th commit and the first 4 flits read back intact. Repeat with ready_i pulsed on the 5th commit edge: required: all 5 flits are accepted.
- Framing (MB_RX_FRAMING_CHECK_EN): drop valid_pin_i to 0 at UI 2 of fragment 1. Required: framing_err_o pulses once, FSM returns to IDLE, nothing is committed, and the next clean flit is received correctly.
- Reset mid-flit: assert reset at UI 17 while 2 flits are buffered. Required: all outputs return to reset values, and the next flit after reset is received correctly.
